// File: rtl/median_pkg.sv
// Shared types and constants for the vertical 3-tap median column controller.
package median_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/median_col_ctrl_line_buf.sv
// Two-row shift memory: each write moves the column up one row; taps show the pre-write contents.
module line_buf
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         tap0_c,
  output logic [PIX_W-1:0]         tap1_c
);

  logic [PIX_W-1:0] row0 [IMG_W];
  logic [PIX_W-1:0] row1 [IMG_W];

  assign tap0_c = row0[addr];
  assign tap1_c = row1[addr];

  // Contents are deliberately not reset; the fill rows overwrite them before first use.
  always_ff @(posedge clk) begin
    if (we) begin
      row0[addr] <= row1[addr];
      row1[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_col_ctrl.sv
// Raster-stream controller producing a vertical 3-tap median for each interior-row pixel.
module median_col_ctrl
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_pix,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PIX_W-1:0]         out_pix,
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_H)-1:0] out_y,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  state_t          state, state_next;
  logic [XW-1:0]   x, x_next;
  logic [YW-1:0]   y, y_next;
  logic            accept_c;
  logic            last_col_c;
  logic [PIX_W-1:0] tap0_c, tap1_c;

  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    logic [PIX_W-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      return lo;
    else if (c > hi) return hi;
    else             return c;
  endfunction

  assign accept_c   = in_valid & in_ready;
  assign last_col_c = (x == XW'(IMG_W - 1));

  line_buf #(.IMG_W(IMG_W)) u_line_buf (
    .clk    (clk),
    .we     (accept_c),
    .addr   (x),
    .wdata  (in_pix),
    .tap0_c (tap0_c),
    .tap1_c (tap1_c)
  );

  // Next-state and raster counter logic
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FILL;
          x_next     = '0;
          y_next     = '0;
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept_c) begin
          x_next = last_col_c ? '0 : x + XW'(1);
          y_next = last_col_c ? y + YW'(1) : y;
          if (state == ST_FILL && last_col_c && y == YW'(1))
            state_next = ST_RUN;
          if (state == ST_RUN && last_col_c && y == YW'(IMG_H - 1))
            state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      x        <= '0;
      y        <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      x        <= x_next;
      y        <= y_next;
      in_ready <= (state_next == ST_FILL) || (state_next == ST_RUN);
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
    end
  end

  // Median output register; centre row is the one above the incoming pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= accept_c && (state == ST_RUN);
      if (accept_c && state == ST_RUN) begin
        out_pix <= med3(tap0_c, tap1_c, in_pix);
        out_x   <= x;
        out_y   <= y - YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_median_col_ctrl.sv
// Directed scoreboard bench for median_col_ctrl on a 4x4 frame.
module tb_median_col_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pix = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_pix;
  logic [1:0] out_x;
  logic [1:0] out_y;
  logic       busy;
  logic       done;

  median_col_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pix   (out_pix),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    int         x;
    int         y;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] obs_pix[$];
  int         obs_y[$];
  logic [7:0] img [H][W];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int outs     = 0;
  int dones    = 0;
  int bx       = 0;
  int by       = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference median: the value with at least two taps <= it and two taps >= it.
  function automatic logic [7:0] med_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v [3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      int le, ge;
      le = 0; ge = 0;
      for (int j = 0; j < 3; j++) begin
        if (v[j] <= v[i]) le++;
        if (v[j] >= v[i]) ge++;
      end
      if (le >= 2 && ge >= 2) return v[i];
    end
    return 8'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        outs++;
        obs_pix.push_back(out_pix);
        obs_y.push_back(int'(out_y));
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_pix", 32'(out_pix), 32'(e.pix));
          check("out_x",   32'(out_x),   32'(e.x));
          check("out_y",   32'(out_y),   32'(e.y));
          check("out_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done) dones++;
    end
  end

  task automatic send_pix(input int gap, input bit st);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_pix   = img[by][bx];
    start    = st;
    check("in_ready_streaming", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (by >= 2)
      sb.push_back('{pix: med_ref(img[by-2][bx], img[by-1][bx], img[by][bx]), x: bx, y: by - 1, cyc: cyc});
    last_cyc = cyc;
    if (bx == W - 1) begin
      bx = 0;
      by++;
    end else begin
      bx++;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    bx = 0;
    by = 0;
    outs = 0;
    obs_pix.delete();
    obs_y.delete();
  endtask

  task automatic run_frame(input int gap, input int start_idx);
    bit seen;
    do_start();
    for (int i = 0; i < int'(W * H); i++) send_pix(gap, i == start_idx);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_cycle", 32'(cyc), 32'(last_cyc + 1));
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd0);
    check("frame_out_count", 32'(outs), 32'((H - 2) * W));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        img[y][x] = 8'(y * 4 + x);
  endtask

  task automatic check_ramp_outputs(input string tag);
    if (obs_pix.size() != 8) begin
      check({tag, "_obs_size"}, 32'(obs_pix.size()), 32'd8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        check({tag, "_pix"}, 32'(obs_pix[i]), 32'(4 + i));
        check({tag, "_row"}, 32'(obs_y[i]), 32'(1 + i / 4));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Ramp frame, continuous stream
    fill_ramp();
    run_frame(0, -1);
    check_ramp_outputs("ramp");

    // Specific column taps with a stray start mid-frame
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        img[y][x] = 8'($urandom_range(0, 255));
    img[0][0] = 8'd10;  img[1][0] = 8'd200; img[2][0] = 8'd50;
    img[0][1] = 8'd7;   img[1][1] = 8'd7;   img[2][1] = 8'd9;
    img[0][2] = 8'd255; img[1][2] = 8'd0;   img[2][2] = 8'd255;
    run_frame(0, 9);
    if (obs_pix.size() >= 3) begin
      check("col_taps_10_200_50", 32'(obs_pix[0]), 32'd50);
      check("tie_7_7_9", 32'(obs_pix[1]), 32'd7);
      check("tie_255_0_255", 32'(obs_pix[2]), 32'd255);
    end else begin
      check("taps_obs_size", 32'(obs_pix.size()), 32'd8);
    end

    // Ramp frame with in_valid toggling
    fill_ramp();
    run_frame(1, -1);
    check_ramp_outputs("bubble");

    // Asynchronous reset during row 2, then a clean frame
    fill_ramp();
    do_start();
    for (int i = 0; i < 10; i++) send_pix(0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_pix", 32'(out_pix), 32'd0);
    check("async_rst_out_x", 32'(out_x), 32'd0);
    check("async_rst_out_y", 32'(out_y), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_stays_idle", 32'(busy), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    run_frame(0, -1);
    check_ramp_outputs("after_reset");

    check("frames_done", 32'(dones), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/median_col_ctrl.md
MEDIAN_COL_CTRL -- requirements
Module: median_col_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per row (4..1024).
REQ-002 SHALL have parameter IMG_H, default 64, rows per frame (3..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port in_valid  input  1  in_pix holds a valid pixel.
REQ-007 SHALL have port in_pix  input  8  raster-order pixel (row-major, x fastest).
REQ-008 SHALL have port in_ready  output  1  controller accepts in_pix this cycle.
REQ-009 SHALL have port out_valid  output  1  out_pix/out_x/out_y valid, single-cycle strobe.
REQ-010 SHALL have port out_pix  output  8  vertical 3-tap median result.
REQ-011 SHALL have ports out_x/out_y  output  clog2(IMG_W)/clog2(IMG_H)  coordinates of the centre pixel.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM IDLE, FILL, RUN, FLUSH, DONE.
REQ-015 IDLE: in_ready=0; start -> FILL, clear x,y counters; start outside IDLE SHALL be ignored.
REQ-016 FILL/RUN: in_ready=1; a pixel is accepted when in_valid&&in_ready.
REQ-017 Per accepted pixel at (x,y): taps val_0=lb0[x], val_1=lb1[x], val_2=in_pix; then lb0[x]<=lb1[x], lb1[x]<=in_pix in the same edge (read-before-write).
REQ-018 Counter rules: x increments per accept; x==IMG_W-1 wraps to 0 and y increments; no accept -> counters hold.
REQ-019 FILL -> RUN on accept of (IMG_W-1, 1); FILL SHALL produce no output.
REQ-020 RUN: each accept SHALL yield out_valid exactly one cycle later with out_pix=median(val_0,val_1,val_2), out_x=x, out_y=y-1.
REQ-021 RUN -> FLUSH on accept of (IMG_W-1, IMG_H-1); FLUSH lasts one cycle (drains median latency), in_ready=0.
REQ-022 FLUSH -> DONE; DONE asserts done for one cycle, then -> IDLE.
REQ-023 Total out_valid pulses per frame SHALL equal (IMG_H-2)*IMG_W; rows 0 and IMG_H-1 produce no output (no border replication).
REQ-024 Downstream always accepts; no output backpressure exists.
REQ-025 in_valid gaps (bubbles) SHALL only delay output, never corrupt taps or counters.
REQ-026 Median tie rule: equal values return that value; result always equals one of the three taps.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, x=y=0, in_ready=0, out_valid=0, out_pix=0, out_x=0, out_y=0, busy=0, done=0.
REQ-028 Line-buffer contents SHALL NOT be reset; FILL overwrites them before use.
REQ-029 Reset mid-frame SHALL abort the frame; the next frame starts only on a fresh start.

Structure
REQ-030 Package median_pkg SHALL hold the FSM state enum, PIX_W=8 constant.
REQ-031 Sub-module line_buf (IMG_W x 8 two-row shift memory, read-before-write) SHALL be the single child; the median compare logic lives in the controller with its own async-reset output register.

Verification (IMG_W=4, IMG_H=4 unless stated)
REQ-032 Reset then start, stream pixel value = y*4+x continuously -> 8 out_valid pulses; out_pix = 4..11 in order; out_y=1,1,1,1,2,2,2,2; done one cycle after FLUSH.
REQ-033 Column taps (10,200,50) at x=0 of rows 0..2 -> out_pix=50, out_x=0, out_y=1.
REQ-034 Equal taps (7,7,9) -> 7; (255,0,255) -> 255.
REQ-035 in_valid toggling 1/0 every cycle -> same 8 results as REQ-032, each one cycle after its accept.
REQ-036 rst_n low during row 2 -> all outputs 0 immediately (asynchronous); new start gives clean frame matching REQ-032.
REQ-037 start pulsed while busy -> ignored; frame count and done timing unchanged.
